// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - signed multiply-accumulate stage with saturating batch sum
// Products of LEN accepted A/B pairs are summed with clamping and offered downstream.

module multiplier #(
  parameter int N = 5
) (
  input  logic signed [N-1:0]   a_i,
  input  logic signed [N-1:0]   b_i,
  output logic signed [2*N-1:0] p_o
);
  logic signed [2*N-1:0] a_ext;

  assign a_ext = {{N{a_i[N-1]}}, a_i};

  // Shift-add rows of the array; the multiplier MSB carries negative weight.
  always_comb begin
    p_o = '0;
    for (int i = 0; i < N; i++) begin
      if (b_i[i]) begin
        if (i == N - 1) p_o = p_o - (a_ext << i);
        else            p_o = p_o + (a_ext << i);
      end
    end
  end
endmodule

module mac_accumulator #(
  parameter int N     = 5,
  parameter int LEN   = 8,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N-1:0]     A,
  input  logic signed [N-1:0]     B,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_sat
);
  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      p_vld_q, p_vld_d;
  logic signed [2*N-1:0]     p_q, p_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      sat_q, sat_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic                      out_sat_q, out_sat_d;

  logic signed [2*N-1:0]     prod;
  logic                      accept, handshake;
  logic signed [ACC_W:0]     sum_w;
  logic                      clip_pos, clip_neg;
  logic signed [ACC_W-1:0]   sum_sat;

  multiplier #(.N(N)) u_mult (
    .a_i (A),
    .b_i (B),
    .p_o (prod)
  );

  assign accept    = in_valid & in_ready;
  assign handshake = out_valid_q & out_ready;

  // One guard bit exposes overflow; disagreeing top bits mean the sum left range.
  assign sum_w    = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - 2*N){p_q[2*N-1]}}, p_q};
  assign clip_pos = ~sum_w[ACC_W] &  sum_w[ACC_W-1];
  assign clip_neg =  sum_w[ACC_W] & ~sum_w[ACC_W-1];
  assign sum_sat  = clip_pos ? {1'b0, {(ACC_W-1){1'b1}}} :
                    clip_neg ? {1'b1, {(ACC_W-1){1'b0}}} :
                    sum_w[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_ACC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (accept && cnt_q == LAST) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (handshake) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_ACC);
  end

  always_comb begin
    cnt_d       = cnt_q;
    p_vld_d     = accept;
    p_d         = accept ? prod : p_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_sat_d   = out_sat_q;
    if (accept) cnt_d = cnt_q + CNT_W'(1);
    if (p_vld_q) begin
      acc_d = sum_sat;
      if (clip_pos || clip_neg) sat_d = 1'b1;
    end
    // First DONE cycle: acc already holds the last product, so publish it.
    if (state_q == S_DONE && !out_valid_q) begin
      out_valid_d = 1'b1;
      out_acc_d   = acc_q;
      out_sat_d   = sat_q;
    end
    if (handshake) begin
      out_valid_d = 1'b0;
      acc_d       = '0;
      sat_d       = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      p_vld_q     <= 1'b0;
      p_q         <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      p_vld_q     <= p_vld_d;
      p_q         <= p_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - self-checking bench for mac_accumulator at ACC_W=16 and ACC_W=10
// Both instances share stimulus; a transaction-level model predicts handshakes and sums.

module tb_mac_accumulator;
  localparam int N   = 5;
  localparam int LEN = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [N-1:0] A = '0;
  logic signed [N-1:0] B = '0;

  logic in_ready16, in_ready10, out_valid16, out_valid10, out_sat16, out_sat10;
  logic signed [15:0] out_acc16;
  logic signed [9:0]  out_acc10;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int r_cyc = 0;
  int r_acc16 = 0, r_acc10 = 0;
  bit r_sat16 = 0, r_sat10 = 0;

  mac_accumulator #(.N(N), .LEN(LEN), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .A(A), .B(B),
    .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16), .out_sat(out_sat16)
  );

  mac_accumulator #(.N(N), .LEN(LEN), .ACC_W(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready10), .A(A), .B(B),
    .out_valid(out_valid10), .out_ready(out_ready), .out_acc(out_acc10), .out_sat(out_sat10)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: the batch result is the clamped running sum of the products, in arrival order.
  int m_prods[$];
  int m_cnt = 0, m_wait = 0;
  bit m_valid = 0, m_live = 0;
  int m_acc16 = 0, m_acc10 = 0;
  bit m_sat16 = 0, m_sat10 = 0;

  function automatic void sat_sum(input int w, input int prods[$], output int acc, output bit s);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    acc = 0;
    s = 0;
    foreach (prods[k]) begin
      acc += prods[k];
      if (acc > hi) begin acc = hi; s = 1; end
      else if (acc < lo) begin acc = lo; s = 1; end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1; m_cnt = 0; m_wait = 0; m_valid = 0;
      m_prods.delete();
    end else if (m_live) begin
      if (m_valid) begin
        if (out_ready) begin m_valid = 0; m_cnt = 0; end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1;
          sat_sum(16, m_prods, m_acc16, m_sat16);
          sat_sum(10, m_prods, m_acc10, m_sat10);
          m_prods.delete();
        end
      end else if (m_cnt < LEN && in_valid) begin
        m_prods.push_back(int'(A) * int'(B));
        m_cnt++;
        if (m_cnt == LEN) m_wait = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready16", in_ready16, m_cnt < LEN);
      chk("in_ready10", in_ready10, m_cnt < LEN);
      chk("out_valid16", out_valid16, m_valid);
      chk("out_valid10", out_valid10, m_valid);
      if (m_valid) begin
        chk("out_acc16", out_acc16, m_acc16);
        chk("out_sat16", out_sat16, m_sat16);
        chk("out_acc10", out_acc10, m_acc10);
        chk("out_sat10", out_sat10, m_sat10);
      end
    end
  end

  task automatic send(input int a, input int b);
    int budget;
    budget = 50;
    A = a[N-1:0];
    B = b[N-1:0];
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready16 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL send_timeout: actual=no_accept required=accept");
    end
    @(posedge clk);
    #1;
    last_acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic gap(input int g);
    repeat (g) begin @(posedge clk); #1; end
  endtask

  task automatic wait_result();
    int budget;
    budget = 60;
    @(negedge clk);
    while (!out_valid16 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL result_timeout: actual=no_out_valid required=out_valid");
    end
    r_cyc = cyc;
    r_acc16 = int'(out_acc16);
    r_acc10 = int'(out_acc10);
    r_sat16 = out_sat16;
    r_sat10 = out_sat10;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input int e16, input bit s16, input int e10, input bit s10);
    chk({tag, "_acc16"}, r_acc16, e16);
    chk({tag, "_sat16"}, r_sat16, s16);
    chk({tag, "_acc10"}, r_acc10, e10);
    chk({tag, "_sat10"}, r_sat10, s10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t4a[8];
    int t4b[8];
    int c1, c2, a1, a2;
    t4a = '{3, -4, 15, -16, 2, 0, -7, 1};
    t4b = '{5, 7, 15, 1, -9, 11, -7, 1};

    // T1 reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t1_out_valid", out_valid16, 0);
    chk("t1_out_acc", out_acc16, 0);
    chk("t1_out_sat", out_sat16, 0);
    chk("t1_in_ready", in_ready16, 1);
    @(posedge clk);
    #1;

    // T2 basic
    out_ready = 1'b1;
    for (int i = 0; i < LEN; i++) send(3, -2);
    wait_result();
    chk("t2_latency", r_cyc - last_acc_cyc, 2);
    chk_res("t2", -48, 0, -48, 0);
    chk("t2_model_pin", m_acc16, -48);

    // T3 corner product and saturation
    for (int i = 0; i < LEN; i++) send(-16, -16);
    wait_result();
    chk_res("t3a", 2048, 0, 511, 1);
    for (int i = 0; i < LEN; i++) send(-16, 15);
    wait_result();
    chk_res("t3b", -1920, 0, -512, 1);

    // T4 gaps and backpressure
    out_ready = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      gap($urandom_range(1, 3));
      send(t4a[i], t4b[i]);
    end
    wait_result();
    chk_res("t4", 228, 0, 228, 0);
    in_valid = 1'b1;
    A = 5'sd5;
    B = 5'sd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_in_ready", in_ready16, 0);
      chk("t4_hold_valid", out_valid16, 1);
      chk("t4_hold_acc", out_acc16, 228);
      chk("t4_hold_sat", out_sat16, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // T5 reset mid-batch
    for (int i = 0; i < 3; i++) send(7, 7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < LEN; i++) send(1, 1);
    wait_result();
    chk_res("t5", 8, 0, 8, 0);

    // T6 back-to-back batches
    c1 = 0; c2 = 0; a1 = 0; a2 = 0;
    fork
      begin
        for (int i = 0; i < LEN; i++) send(2, 2);
        for (int i = 0; i < LEN; i++) send(-1, 1);
      end
      begin
        wait_result();
        c1 = r_cyc; a1 = r_acc16;
        chk("t6_b1_sat", r_sat16, 0);
        wait_result();
        c2 = r_cyc; a2 = r_acc16;
        chk("t6_b2_sat", r_sat16, 0);
      end
    join
    chk("t6_b1_acc", a1, 32);
    chk("t6_b2_acc", a2, -8);
    chk("t6_period", c2 - c1, 11);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
